// File: rtl/cnn_pkg.sv
// Shared CNN dimensions: conv1 feature maps, pooled maps and sample width.
// conv2 consumes the same constants so the layers stay in step.
package cnn_pkg;
  localparam int CONV_BIT = 12;
  localparam int CONV1_W  = 24;
  localparam int CONV1_H  = 24;
  localparam int POOL_W   = 12;
  localparam int POOL_H   = 12;
  localparam int NUM_CH   = 3;
endpackage

// File: rtl/maxpool_relu_ch.sv
// One channel of the 2x2 max-pool + ReLU: pair register, half-line buffer,
// signed comparators and the registered rectified output.
module maxpool_relu_ch #(
  parameter int CONV_BIT = cnn_pkg::CONV_BIT,
  parameter int IN_WIDTH = cnn_pkg::CONV1_W,
  parameter int IDX_W    = $clog2(IN_WIDTH / 2)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [CONV_BIT-1:0] pixel,
  input  logic                       pair_load,
  input  logic                       buf_write,
  input  logic                       pool_fire,
  input  logic        [IDX_W-1:0]    idx,
  output logic signed [CONV_BIT-1:0] max_value
);

  function automatic logic signed [CONV_BIT-1:0] smax(
    input logic signed [CONV_BIT-1:0] a,
    input logic signed [CONV_BIT-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [CONV_BIT-1:0] relu(
    input logic signed [CONV_BIT-1:0] x
  );
    return (x > 0) ? x : '0;
  endfunction

  logic signed [CONV_BIT-1:0] pair_p0;
  logic signed [CONV_BIT-1:0] h_p0;
  logic signed [CONV_BIT-1:0] m_p0;
  logic signed [CONV_BIT-1:0] line_buf [IN_WIDTH/2];

  // stage p0: horizontal max of the pair, then vertical max against the stored row
  assign h_p0 = smax(pair_p0, pixel);
  assign m_p0 = relu(smax(line_buf[idx], h_p0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_p0   <= '0;
      max_value <= '0;
      for (int i = 0; i < IN_WIDTH / 2; i++) line_buf[i] <= '0;
    end else begin
      if (pair_load) pair_p0 <= pixel;
      if (buf_write) line_buf[idx] <= h_p0;
      if (pool_fire) max_value <= m_p0;
    end
  end

endmodule

// File: rtl/maxpool_relu.sv
// Streaming 2x2 max-pool + ReLU over three conv1 channels in raster order.
// Shared column/row counters decode the strobes that drive each channel slice.
module maxpool_relu #(
  parameter int CONV_BIT  = cnn_pkg::CONV_BIT,
  parameter int IN_WIDTH  = cnn_pkg::CONV1_W,
  parameter int IN_HEIGHT = cnn_pkg::CONV1_H
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic signed [CONV_BIT-1:0] conv_out_1,
  input  logic signed [CONV_BIT-1:0] conv_out_2,
  input  logic signed [CONV_BIT-1:0] conv_out_3,
  output logic signed [CONV_BIT-1:0] max_value_1,
  output logic signed [CONV_BIT-1:0] max_value_2,
  output logic signed [CONV_BIT-1:0] max_value_3,
  output logic                       valid_out_relu
);
  import cnn_pkg::*;

  localparam int COL_W = $clog2(IN_WIDTH);
  localparam int ROW_W = $clog2(IN_HEIGHT);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_HEIGHT - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             pair_load;
  logic             buf_write;
  logic             pool_fire;

  logic signed [CONV_BIT-1:0] pix [NUM_CH];
  logic signed [CONV_BIT-1:0] res [NUM_CH];

  // Column parity selects pair vs. compare; row parity selects store vs. emit.
  assign pair_load = valid_in & ~col[0];
  assign buf_write = valid_in &  col[0] & ~row[0];
  assign pool_fire = valid_in &  col[0] &  row[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col            <= '0;
      row            <= '0;
      valid_out_relu <= 1'b0;
    end else begin
      valid_out_relu <= pool_fire;
      if (valid_in) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  assign pix[0] = conv_out_1;
  assign pix[1] = conv_out_2;
  assign pix[2] = conv_out_3;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    maxpool_relu_ch #(
      .CONV_BIT (CONV_BIT),
      .IN_WIDTH (IN_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .pixel     (pix[g]),
      .pair_load (pair_load),
      .buf_write (buf_write),
      .pool_fire (pool_fire),
      .idx       (col[COL_W-1:1]),
      .max_value (res[g])
    );
  end

  assign max_value_1 = res[0];
  assign max_value_2 = res[1];
  assign max_value_3 = res[2];

endmodule

// File: tb/tb_maxpool_relu.sv
// Scoreboard bench for maxpool_relu: expected triples are queued as windows
// complete and popped when valid_out_relu pulses.
module tb_maxpool_relu;

  localparam int W = 24;
  localparam int H = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic signed [11:0] conv_out_1 = '0, conv_out_2 = '0, conv_out_3 = '0;
  logic signed [11:0] max_value_1, max_value_2, max_value_3;
  logic valid_out_relu;

  maxpool_relu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .conv_out_1     (conv_out_1),
    .conv_out_2     (conv_out_2),
    .conv_out_3     (conv_out_3),
    .max_value_1    (max_value_1),
    .max_value_2    (max_value_2),
    .max_value_3    (max_value_3),
    .valid_out_relu (valid_out_relu)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [11:0] a;
    logic signed [11:0] b;
    logic signed [11:0] c;
  } trip_t;

  trip_t sb[$];
  trip_t mon_t;
  logic signed [11:0] rnd [3][H][W];
  logic signed [11:0] last_1, last_2, last_3;
  int n_tests = 0;
  int n_fail  = 0;
  int tr = 0, tc = 0, k_out = 0, pulses = 0, p0 = 0;
  bit exp_fire = 1'b0;
  bit prev_rst = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // mode 0 ramp, 1 relu pattern, 2 signed extremes, 3 random
  function automatic logic signed [11:0] pix(input int mode, input int ch, input int r, input int c);
    int q;
    q = (r % 2) * 2 + (c % 2);
    case (mode)
      0: return 12'(r * W + c);
      1: begin
        if (ch == 0) return -12'sd5;
        if (ch == 2) return 12'sd0;
        case (q)
          0: return -12'sd7;
          1: return 12'sd3;
          2: return -12'sd1;
          default: return -12'sd2;
        endcase
      end
      2: begin
        if (ch == 1) return -12'sd2048;
        if (ch == 2) return 12'(r * W + c - 300);
        case (q)
          0: return -12'sd2048;
          1: return 12'sd2047;
          2: return -12'sd1;
          default: return 12'sd0;
        endcase
      end
      default: return rnd[ch][r][c];
    endcase
  endfunction

  function automatic int model(input int mode, input int ch, input int r, input int c);
    int m, v;
    m = -100000;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        v = int'(pix(mode, ch, r - dr, c - dc));
        if (v > m) m = v;
      end
    return (m > 0) ? m : 0;
  endfunction

  task automatic drive_beat(input int mode);
    trip_t t;
    int v;
    conv_out_1 = pix(mode, 0, tr, tc);
    conv_out_2 = pix(mode, 1, tr, tc);
    conv_out_3 = pix(mode, 2, tr, tc);
    valid_in   = 1'b1;
    exp_fire   = (tr % 2 == 1) && (tc % 2 == 1);
    if (exp_fire) begin
      if (mode == 0) begin
        v = (2 * (k_out / 12) + 1) * W + 2 * (k_out % 12) + 1;
        t.a = 12'(v); t.b = 12'(v); t.c = 12'(v);
      end else begin
        t.a = 12'(model(mode, 0, tr, tc));
        t.b = 12'(model(mode, 1, tr, tc));
        t.c = 12'(model(mode, 2, tr, tc));
      end
      sb.push_back(t);
      k_out++;
    end
    if (tc == W - 1) begin
      tc = 0;
      tr = (tr == H - 1) ? 0 : tr + 1;
      if (tr == 0) k_out = 0;
    end else begin
      tc++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    valid_in   = 1'b0;
    exp_fire   = 1'b0;
    conv_out_1 = 12'($urandom);
    conv_out_2 = 12'($urandom);
    conv_out_3 = 12'($urandom);
    @(negedge clk);
  endtask

  task automatic send(input int mode, input int nbeats, input bit gap);
    for (int i = 0; i < nbeats; i++) begin
      if (gap) begin
        for (int j = 0; j < 8 && $urandom_range(1, 0) == 1; j++) idle();
      end
      drive_beat(mode);
    end
    valid_in = 1'b0;
    exp_fire = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int mode, input bit gap, input int frames);
    p0 = pulses;
    send(mode, frames * W * H, gap);
    repeat (3) idle();
    chk(tag, pulses - p0, frames * (W / 2) * (H / 2));
  endtask

  always @(posedge clk) begin
    #1;
    if (valid_out_relu || exp_fire) begin
      chk("pulse_timing", int'(valid_out_relu), int'(exp_fire));
      if (valid_out_relu) pulses++;
      if (exp_fire) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          mon_t = sb.pop_front();
          chk("max_value_1", int'(max_value_1), int'(mon_t.a));
          chk("max_value_2", int'(max_value_2), int'(mon_t.b));
          chk("max_value_3", int'(max_value_3), int'(mon_t.c));
        end
      end
    end else if (rst_n && prev_rst) begin
      chk("hold_1", int'(max_value_1), int'(last_1));
      chk("hold_2", int'(max_value_2), int'(last_2));
      chk("hold_3", int'(max_value_3), int'(last_3));
    end
    last_1   = max_value_1;
    last_2   = max_value_2;
    last_3   = max_value_3;
    prev_rst = rst_n;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < H; r++)
        for (int x = 0; x < W; x++) rnd[c][r][x] = 12'($urandom);

    // reset held with random inputs
    rst_n = 1'b0;
    repeat (6) begin
      @(negedge clk);
      valid_in   = 1'($urandom);
      conv_out_1 = 12'($urandom);
      conv_out_2 = 12'($urandom);
      conv_out_3 = 12'($urandom);
      #2;
      chk("rst_mv1", int'(max_value_1), 0);
      chk("rst_mv2", int'(max_value_2), 0);
      chk("rst_mv3", int'(max_value_3), 0);
      chk("rst_vld", int'(valid_out_relu), 0);
    end
    @(negedge clk);
    valid_in = 1'b0;
    rst_n    = 1'b1;

    run_frame("ramp_pulses", 0, 1'b0, 1);
    run_frame("relu_pulses", 1, 1'b0, 1);
    run_frame("extreme_pulses", 2, 1'b0, 1);
    run_frame("random_pulses", 3, 1'b0, 1);
    run_frame("gap_ramp_pulses", 0, 1'b1, 1);
    run_frame("gap_random_pulses", 3, 1'b1, 1);

    // mid-frame reset abandons the partial frame
    send(0, 300, 1'b0);
    idle();
    rst_n = 1'b0;
    repeat (2) idle();
    chk("midrst_vld", int'(valid_out_relu), 0);
    chk("midrst_mv1", int'(max_value_1), 0);
    sb.delete();
    tr = 0; tc = 0; k_out = 0;
    rst_n = 1'b1;
    run_frame("midrst_ramp_pulses", 0, 1'b0, 1);

    run_frame("b2b_pulses", 0, 1'b0, 2);

    repeat (3) idle();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool_relu.md
# maxpool_relu

Streaming 2x2 max-pool plus ReLU stage between the first convolution layer and the second. It takes three 24x24 conv1 feature-map channels in raster order, one pixel per channel per valid cycle. It emits three 12x12 pooled, rectified channels as the 12-bit streams `max_value_1..3` qualified by `valid_out_relu`, which is the input protocol the conv2 layer consumes. The block is fully pipelined and processes one input beat per cycle. It has no backpressure.

## Interface
- `CONV_BIT`, 12: signed width of input and output samples.
- `IN_WIDTH`, 24: input feature-map width in pixels. Must be even.
- `IN_HEIGHT`, 24: input feature-map height in rows. Must be even.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_in` in 1: the three `conv_out_*` inputs carry one pixel each this cycle.
- `conv_out_1`, `conv_out_2`, `conv_out_3` in `CONV_BIT`: signed conv1 outputs, raster order, all three at the same position.
- `max_value_1`, `max_value_2`, `max_value_3` out `CONV_BIT`: pooled, rectified outputs, registered.
- `valid_out_relu` out 1: one-cycle pulse marking a valid pooled triple.

## Operation
- Position tracking:
  - One shared column counter, 0..`IN_WIDTH`-1, and one row counter, 0..`IN_HEIGHT`-1.
  - Both advance only on `valid_in`. Column wraps to 0 and increments row. Row wraps to 0 after the last row, so back-to-back frames need no re-init.
- Per channel, on a `valid_in` beat:
  - Even column: store the pixel in the pair register.
  - Odd column: horizontal max `h = max(pair_reg, pixel)`.
  - Even row, odd column: write `h` into the half-line buffer at index column/2. The buffer has `IN_WIDTH`/2 entries of `CONV_BIT` bits.
  - Odd row, odd column: `m = max(buffer[column/2], h)`, then output `m` if `m > 0`, else 0. Assert `valid_out_relu`.
- All comparisons are signed two's complement. Ties pick either operand; the result is identical.
- ReLU: negative values and zero both produce 0. Positive values pass unchanged. The output remains representable in `CONV_BIT` bits.
- The three channels share the counters and `valid_in`, so their outputs are always position-aligned.
- Gaps in `valid_in` are allowed anywhere, including mid-row and mid-pair. The counters, pair registers and buffer hold their values across gaps.
- Each frame produces exactly (`IN_WIDTH`/2)*(`IN_HEIGHT`/2) = 144 output beats.

## Timing
- Latency: output registered on the clock edge that samples the 4th pixel of a 2x2 window (odd row, odd column). `valid_out_relu` is high for the following cycle only.
- `valid_out_relu` is low in every cycle not preceded by a completing beat.
- Output pulse spacing:
  - Within odd rows, at most one pulse per 2 input beats.
  - Even rows produce no pulses.
- `max_value_*` hold their last value while `valid_out_relu` is low.
- Reset values:
  - `max_value_*` = 0, `valid_out_relu` = 0.
  - Counters = 0.
  - Pair registers and buffer = 0.
  - Asserting reset mid-frame abandons the partial frame. The first beat after release is treated as row 0, column 0.
- `valid_in` high in the first cycle after reset deassertion is accepted.

## Structure
- Shared package `cnn_pkg`: `CONV_BIT`, the conv1 output dimensions (24x24), the pooled dimensions (12x12) and the channel count (3). Conv2 uses the same constants.
- Top `maxpool_relu`:
  - Owns the column/row counters and derives the decode strobes `pair_load`, `buf_write`, `pool_fire`.
  - Instantiates sub-module `maxpool_relu_ch` three times.
  - ANDs nothing: a single `valid_out_relu` register.
- `maxpool_relu_ch`: one channel's pair register, half-line buffer, signed comparators, ReLU and output register. It is driven by the shared strobes and the column/2 index.

## Test plan
- Reset check: hold `rst_n` = 0 with random inputs. All outputs must be 0 and `valid_out_relu` must be 0. Release reset and feed a full frame; exactly 144 pulses must follow.
- Ramp frame: all channels get `row*24+col` (max 575, in range). Output k must equal (2*(k/12)+1)*24 + 2*(k%12)+1. First output = 25, last = 575.
- ReLU check: channel 1 all -5, channel 2 window {-7, 3, -1, -2} in every window, channel 3 all 0. Outputs must be 0, 3 and 0 respectively for all 144 beats.
- Signed extremes: a window of {-2048, 2047, -1, 0} must output 2047. A window of {-2048, -2048, -2048, -2048} must output 0.
- Gapped input: the ramp frame with `valid_in` toggling pseudo-randomly (~50% duty) must produce outputs identical to the gap-free run. Each pulse must come exactly 1 cycle after its completing beat.
- Mid-frame reset and back-to-back frames:
  - Reset after 300 beats, then send a full ramp frame. The result must match the clean ramp run.
  - Two consecutive frames with no idle cycle must yield 288 pulses, and frame 2 must match frame 1.
